// File: rtl/traffic_spawn_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : traffic_spawn_scheduler
// Purpose  : Spawns enemy traffic into four car slots, one spawn per frame gap,
//            rotating slot priority from an LFSR. Optional macro: FUEL_SPAWN_EN
// Revision : 1.0 - initial release
// ============================================================================
module traffic_spawn_scheduler #(
  parameter int         SPAWN_GAP_FRAMES = 40,
  parameter int         TRUCK_PERIOD     = 4,
  parameter int         FUEL_PERIOD      = 8,
  parameter logic [7:0] LFSR_SEED        = 8'hA5
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       enable,
  input  logic [3:0] slot_busy,
  output logic [3:0] spawn,
  output logic [3:0] truck_flag,
  output logic       fuel_spawn,
  output logic [7:0] spawn_count
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_GAP = 3'd1;
  localparam logic [2:0] S_PICK     = 3'd2;
  localparam logic [2:0] S_STALL    = 3'd3;
  localparam logic [2:0] S_ISSUE    = 3'd4;

  localparam logic [7:0] c_GAP        = 8'(SPAWN_GAP_FRAMES);
  localparam logic [3:0] c_TRUCK_LAST = 4'(TRUCK_PERIOD - 1);

  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  logic [7:0] r_gap_cnt;
  logic [7:0] r_lfsr;
  logic [7:0] r_spawn_count;
  logic [3:0] r_truck_cnt;
  logic [3:0] r_truck_flag;
  logic [3:0] r_spawn;
  logic       w_lfsr_fb;
  logic       w_found;
  logic [1:0] w_pick;
  logic [1:0] w_cand;
  logic       w_issue;
  logic       w_gap_load;
  logic [3:0] w_spawn_nxt;

  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  // First free slot searching upward (mod 4) from the LFSR start index
  always_comb begin
    w_found = 1'b0;
    w_pick  = 2'd0;
    w_cand  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      w_cand = r_lfsr[1:0] + 2'(i);
      if (!w_found && !slot_busy[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     w_state_nxt = S_WAIT_GAP;
        S_WAIT_GAP: if (startOfFrame && (r_gap_cnt == 8'd1)) w_state_nxt = S_PICK;
        S_PICK:     w_state_nxt = w_found ? S_ISSUE : S_STALL;
        S_STALL:    if (startOfFrame && (slot_busy != 4'b1111)) w_state_nxt = S_PICK;
        S_ISSUE:    w_state_nxt = S_WAIT_GAP;
        default:    w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Spawn is registered at the PICK->ISSUE edge so the pulse is visible during ISSUE
  always_comb begin
    w_issue     = (r_state == S_PICK) && enable && w_found;
    w_spawn_nxt = w_issue ? (4'b0001 << w_pick) : 4'b0000;
    w_gap_load  = ((r_state == S_IDLE) && enable) || (r_state == S_ISSUE);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_spawn       <= 4'b0000;
      r_lfsr        <= LFSR_SEED;
      r_gap_cnt     <= 8'd0;
      r_truck_flag  <= 4'b0000;
      r_truck_cnt   <= 4'd0;
      r_spawn_count <= 8'd0;
    end else begin
      r_spawn <= w_spawn_nxt;
      if (startOfFrame) r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
      if (w_gap_load)
        r_gap_cnt <= c_GAP;
      else if ((r_state == S_WAIT_GAP) && startOfFrame)
        r_gap_cnt <= r_gap_cnt - 8'd1;
      if (w_issue) begin
        r_truck_flag[w_pick] <= (r_truck_cnt == c_TRUCK_LAST);
        r_truck_cnt          <= (r_truck_cnt == c_TRUCK_LAST) ? 4'd0 : r_truck_cnt + 4'd1;
        r_spawn_count        <= r_spawn_count + 8'd1;
      end
    end
  end

`ifdef FUEL_SPAWN_EN
  localparam logic [7:0] c_FUEL_LAST = 8'(FUEL_PERIOD - 1);

  logic [7:0] r_fuel_cnt;
  logic       r_fuel_spawn;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_fuel_cnt   <= 8'd0;
      r_fuel_spawn <= 1'b0;
    end else begin
      r_fuel_spawn <= w_issue && (r_fuel_cnt == c_FUEL_LAST);
      if (w_issue)
        r_fuel_cnt <= (r_fuel_cnt == c_FUEL_LAST) ? 8'd0 : r_fuel_cnt + 8'd1;
    end
  end

  assign fuel_spawn = r_fuel_spawn;
`else
  logic w_fuel_unused;
  assign w_fuel_unused = (FUEL_PERIOD != 0);
  assign fuel_spawn    = 1'b0;
`endif

  assign spawn       = r_spawn;
  assign truck_flag  = r_truck_flag;
  assign spawn_count = r_spawn_count;

endmodule
`default_nettype wire

// File: tb/tb_traffic_spawn_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_spawn_scheduler
// Purpose  : Directed bench for traffic_spawn_scheduler (gap = 2 frames).
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_spawn_scheduler;

  typedef struct {
    logic [3:0] busy;
    logic       truck;
    logic [7:0] count;
  } vec_t;

  logic       clk = 1'b0;
  logic       resetN;
  logic       sof;
  logic       enable;
  logic [3:0] busy;
  logic [3:0] spawn;
  logic [3:0] truck_flag;
  logic       fuel_spawn;
  logic [7:0] spawn_count;

  int n_vec = 0;
  int n_bad = 0;
  int n_pulses = 0;
  int n_multi = 0;
  int n_b2b = 0;
  logic [3:0] prev_spawn = 4'b0000;

  logic [7:0] m_lfsr;
  logic [3:0] m_tf;
  vec_t       tbl [8];

  traffic_spawn_scheduler #(
    .SPAWN_GAP_FRAMES(2),
    .TRUCK_PERIOD    (4),
    .FUEL_PERIOD     (8),
    .LFSR_SEED       (8'hA5)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .startOfFrame(sof),
    .enable      (enable),
    .slot_busy   (busy),
    .spawn       (spawn),
    .truck_flag  (truck_flag),
    .fuel_spawn  (fuel_spawn),
    .spawn_count (spawn_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (spawn != 4'b0000) begin
      n_pulses++;
      if (!$onehot(spawn)) n_multi++;
      if (prev_spawn != 4'b0000) n_b2b++;
    end
    prev_spawn = spawn;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [1:0] first_free(input logic [7:0] l, input logic [3:0] b);
    logic [1:0] c;
    for (int i = 0; i < 4; i++) begin
      c = l[1:0] + 2'(i);
      if (!b[c]) return c;
    end
    return 2'd0;
  endfunction

  function automatic logic exp_fuel(input logic [7:0] c);
`ifdef FUEL_SPAWN_EN
    return (c[2:0] == 3'd0);
`else
    return 1'b0;
`endif
  endfunction

  // Returns at the negedge following the startOfFrame edge
  task automatic sof_pulse();
    @(negedge clk);
    sof = 1'b1;
    if (resetN) m_lfsr = lfsr_next(m_lfsr);
    @(negedge clk);
    sof = 1'b0;
  endtask

  task automatic frame();
    sof_pulse();
    repeat (2) @(negedge clk);
  endtask

  // Called in the PICK cycle: expects the pulse in the next cycle only
  task automatic check_issue(input string name, input logic [1:0] idx,
                             input logic truck, input logic [7:0] cnt);
    chk({name, "_pick_quiet"}, 32'(spawn), 32'h0);
    @(negedge clk);
    m_tf[idx] = truck;
    chk({name, "_spawn"}, 32'(spawn), 32'(4'b0001 << idx));
    chk({name, "_truck_flag"}, 32'(truck_flag), 32'(m_tf));
    chk({name, "_count"}, 32'(spawn_count), 32'(cnt));
    chk({name, "_fuel"}, 32'(fuel_spawn), 32'(exp_fuel(cnt)));
    @(negedge clk);
    chk({name, "_one_cycle"}, 32'(spawn), 32'h0);
    chk({name, "_fuel_off"}, 32'(fuel_spawn), 32'h0);
  endtask

  task automatic do_spawn(input string name, input logic [3:0] b,
                          input logic truck, input logic [7:0] cnt);
    @(negedge clk);
    busy = b;
    frame();
    sof_pulse();
    check_issue(name, first_free(m_lfsr, b), truck, cnt);
  endtask

  initial begin
    int p;
    logic [1:0] idx;

    tbl[0] = '{busy: 4'b0000, truck: 1'b0, count: 8'd1};
    tbl[1] = '{busy: 4'b1110, truck: 1'b0, count: 8'd2};
    tbl[2] = '{busy: 4'b1101, truck: 1'b0, count: 8'd3};
    tbl[3] = '{busy: 4'b1011, truck: 1'b1, count: 8'd4};
    tbl[4] = '{busy: 4'b0111, truck: 1'b0, count: 8'd5};
    tbl[5] = '{busy: 4'b0000, truck: 1'b0, count: 8'd6};
    tbl[6] = '{busy: 4'b0101, truck: 1'b0, count: 8'd7};
    tbl[7] = '{busy: 4'b0000, truck: 1'b1, count: 8'd8};

    resetN = 1'b0;
    sof    = 1'b0;
    enable = 1'b0;
    busy   = 4'b0000;
    m_lfsr = 8'hA5;
    m_tf   = 4'b0000;

    repeat (3) @(negedge clk);
    chk("reset_spawn", 32'(spawn), 32'h0);
    chk("reset_truck_flag", 32'(truck_flag), 32'h0);
    chk("reset_count", 32'(spawn_count), 32'h0);
    chk("reset_fuel", 32'(fuel_spawn), 32'h0);
    resetN = 1'b1;

    for (int i = 0; i < 100; i++) frame();
    chk("idle_no_spawn", 32'(n_pulses), 32'd0);
    chk("idle_count", 32'(spawn_count), 32'h0);
    chk("idle_truck_flag", 32'(truck_flag), 32'h0);

    enable = 1'b1;
    for (int i = 0; i < 8; i++)
      do_spawn($sformatf("vec%0d", i), tbl[i].busy, tbl[i].truck, tbl[i].count);

    // All slots busy at PICK -> stall until a slot frees on a frame edge
    @(negedge clk);
    busy = 4'b1111;
    frame();
    sof_pulse();
    p = n_pulses;
    repeat (4) @(negedge clk);
    chk("stall_no_spawn", 32'(n_pulses), 32'(p));
    chk("stall_count", 32'(spawn_count), 32'd8);
    busy = 4'b1011;
    repeat (3) @(negedge clk);
    chk("stall_waits_frame", 32'(n_pulses), 32'(p));
    sof_pulse();
    check_issue("stall_release", 2'd2, 1'b0, 8'd9);

    // Enable drop in WAIT_GAP, then a full gap after re-enable
    busy = 4'b0000;
    frame();
    enable = 1'b0;
    p = n_pulses;
    frame();
    frame();
    chk("drop_gap_no_spawn", 32'(n_pulses), 32'(p));
    enable = 1'b1;
    frame();
    repeat (3) @(negedge clk);
    chk("reenable_full_gap", 32'(n_pulses), 32'(p));
    sof_pulse();
    check_issue("reenable_spawn", first_free(m_lfsr, busy), 1'b0, 8'd10);

    // Enable drop during PICK suppresses the spawn
    frame();
    sof_pulse();
    enable = 1'b0;
    p = n_pulses;
    repeat (3) @(negedge clk);
    chk("pick_drop_no_spawn", 32'(n_pulses), 32'(p));
    chk("pick_drop_count", 32'(spawn_count), 32'd10);
    chk("pick_drop_truck_hold", 32'(truck_flag), 32'(m_tf));
    enable = 1'b1;

    // Asynchronous reset in the middle of the ISSUE pulse
    frame();
    sof_pulse();
    idx = first_free(m_lfsr, busy);
    @(negedge clk);
    chk("pre_reset_spawn", 32'(spawn), 32'(4'b0001 << idx));
    chk("pre_reset_count", 32'(spawn_count), 32'd11);
    #2;
    resetN = 1'b0;
    #1;
    chk("async_reset_spawn", 32'(spawn), 32'h0);
    chk("async_reset_count", 32'(spawn_count), 32'h0);
    chk("async_reset_truck", 32'(truck_flag), 32'h0);
    m_lfsr = 8'hA5;
    m_tf   = 4'b0000;
    @(negedge clk);
    resetN = 1'b1;
    do_spawn("post_reset", 4'b0000, 1'b0, 8'd1);

    repeat (3) @(negedge clk);
    chk("total_pulses", 32'(n_pulses), 32'd12);
    chk("onehot_pulses", 32'(n_multi), 32'd0);
    chk("single_cycle_pulses", 32'(n_b2b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
